// File: rtl/pipe_run_ctrl.sv
// Run/step/breakpoint controller for the 5-stage pipelined CPU.
// Issues a registered one-Clk advance enable that gates all pipeline state.
module pipe_run_ctrl #(
    parameter int DIV        = 5000000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    output logic        advance,
    output logic [1:0]  state,
    output logic        bp_hit,
    output logic [31:0] adv_count
);

    localparam int DIV_W = $clog2(DIV);
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HALT  = 2'b00,
        S_RUN   = 2'b01,
        S_STEP  = 2'b10,
        S_BREAK = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               skip_q, skip_d;
    logic               adv_d;

    logic [1:0]         sync_q;
    logic               deb_level;
    logic [DEB_W-1:0]   deb_cnt;
    logic               step_req;

    // Step button: 2-flop synchroniser, then a level debouncer; step_req
    // pulses for one cycle when the debounced level rises.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_q    <= '0;
            deb_level <= 1'b0;
            deb_cnt   <= '0;
            step_req  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync_q   <= {sync_q[0], step_btn};
            step_req <= 1'b0;
            if (sync_q[1] == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_level <= sync_q[1];
                deb_cnt   <= '0;
                step_req  <= sync_q[1];
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        state_d = state_q;
        div_d   = div_q;
        skip_d  = skip_q;
        adv_d   = 1'b0;
        unique case (state_q)
            S_HALT: begin
                div_d = '0;
                if (step_req) begin
                    state_d = S_STEP;
                end else if (run_sw) begin
                    state_d = S_RUN;
                    skip_d  = 1'b1;
                end
            end
            S_RUN: begin
                // Switch-off beats the tick so no stray advance leaks out.
                if (!run_sw) begin
                    state_d = S_HALT;
                    div_d   = '0;
                end else if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bp_en && (pc == bp_addr) && !skip_q) begin
                        state_d = S_BREAK;
                    end else begin
                        adv_d  = 1'b1;
                        skip_d = 1'b0;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_STEP: begin
                adv_d   = 1'b1;
                state_d = S_HALT;
            end
            S_BREAK: begin
                if (step_req) begin
                    state_d = S_STEP;
                end else if (!run_sw) begin
                    state_d = S_HALT;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_HALT;
            div_q     <= '0;
            skip_q    <= 1'b0;
            advance   <= 1'b0;
            bp_hit    <= 1'b0;
            adv_count <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            skip_q    <= skip_d;
            advance   <= adv_d;
            bp_hit    <= (state_d == S_BREAK);
            adv_count <= adv_count + {31'd0, advance};
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Directed bench for pipe_run_ctrl (DIV=4, DEB_CYCLES=3); inputs are driven
// and outputs sampled on the falling edge of Clk.
module tb_pipe_run_ctrl;

    localparam logic [1:0] HALT = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] STEP = 2'b10;
    localparam logic [1:0] BRK  = 2'b11;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        run_sw;
    logic        step_btn;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic        advance;
    logic [1:0]  state;
    logic        bp_hit;
    logic [31:0] adv_count;

    int checks = 0;
    int errors = 0;

    pipe_run_ctrl #(.DIV(4), .DEB_CYCLES(3)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .run_sw    (run_sw),
        .step_btn  (step_btn),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .pc        (pc),
        .advance   (advance),
        .state     (state),
        .bp_hit    (bp_hit),
        .adv_count (adv_count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic       found;
        logic [0:10] pat;

        Reset = 1'b1; run_sw = 1'b0; step_btn = 1'b0;
        bp_en = 1'b0; bp_addr = 32'h0; pc = 32'h0;
        repeat (3) @(negedge Clk);
        check("rst_state", state, HALT);
        check("rst_advance", advance, 0);
        check("rst_bp_hit", bp_hit, 0);
        check("rst_count", adv_count, 0);
        Reset = 1'b0;

        // Test 1: reset in the middle of RUN while advance is high, count 7.
        run_sw = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge Clk);
            if (advance === 1'b1 && adv_count === 32'd7) found = 1'b1;
        end
        check("t1_reach_count7", found, 1);
        #2 Reset = 1'b1; run_sw = 1'b0;
        #1;
        check("t1_async_advance", advance, 0);
        check("t1_async_state", state, HALT);
        check("t1_async_count", adv_count, 0);
        @(negedge Clk); @(negedge Clk);
        Reset = 1'b0;
        repeat (10) @(negedge Clk);
        check("t1_idle_state", state, HALT);
        check("t1_idle_count", adv_count, 0);
        check("t1_idle_advance", advance, 0);

        // Test 2: free run, pulses at cycles 5,9,...,41 after run_sw set.
        run_sw = 1'b1;
        for (int k = 1; k <= 42; k++) begin
            @(negedge Clk);
            check($sformatf("t2_adv_c%0d", k), advance, (k >= 5 && (k - 5) % 4 == 0) ? 1 : 0);
            check($sformatf("t2_state_c%0d", k), state, RUN);
        end
        check("t2_count", adv_count, 10);
        run_sw = 1'b0;
        @(negedge Clk); @(negedge Clk);
        check("t2_halt", state, HALT);

        // Test 3: bouncy press accepted once: STEP at cycle 10, advance at 11.
        pat = 11'b1010_1111_110;
        for (int i = 0; i <= 24; i++) begin
            if (i > 0) @(negedge Clk);
            check($sformatf("t3_state_c%0d", i), state, (i == 10) ? STEP : HALT);
            check($sformatf("t3_adv_c%0d", i), advance, (i == 11) ? 1 : 0);
            step_btn = (i <= 10) ? pat[i] : 1'b0;
        end
        check("t3_count", adv_count, 11);
        step_btn = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        step_btn = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge Clk);
            check($sformatf("t3_short_adv_c%0d", j), advance, 0);
            check($sformatf("t3_short_state_c%0d", j), state, HALT);
        end
        check("t3_short_count", adv_count, 11);

        // Test 4: skip tick at pc=0x0C, then trap on the tick with pc=0x10.
        bp_en = 1'b1; bp_addr = 32'h0000_0010; pc = 32'h0000_000C;
        run_sw = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge Clk);
            check($sformatf("t4_adv_c%0d", i), advance, (i == 5) ? 1 : 0);
            check($sformatf("t4_state_c%0d", i), state, (i == 9) ? BRK : RUN);
            if (i == 5) pc = 32'h0000_0010;
        end
        check("t4_bp_hit", bp_hit, 1);
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clk);
            check($sformatf("t4_hold_adv_c%0d", i), advance, 0);
        end
        check("t4_hold_state", state, BRK);
        check("t4_hold_bp_hit", bp_hit, 1);
        check("t4_count", adv_count, 12);

        // Test 5: step past the breakpoint, then resume with skip.
        step_btn = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge Clk);
            if (i == 4) step_btn = 1'b0;
            check($sformatf("t5_state_c%0d", i), state,
                  (i == 6) ? STEP : ((i == 7) ? HALT : BRK));
            check($sformatf("t5_adv_c%0d", i), advance, (i == 7) ? 1 : 0);
        end
        check("t5_bp_hit_clear", bp_hit, 0);
        run_sw = 1'b0;
        @(negedge Clk); @(negedge Clk);
        check("t5_halt", state, HALT);
        check("t5_count_step", adv_count, 13);
        run_sw = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge Clk);
            check($sformatf("t5_resume_adv_c%0d", i), advance, (i == 5) ? 1 : 0);
            check($sformatf("t5_resume_state_c%0d", i), state, (i == 9) ? BRK : RUN);
        end
        check("t5_resume_bp_hit", bp_hit, 1);
        check("t5_count", adv_count, 14);

        // Test 6: ignored step in RUN; run_sw drop on the tick cycle.
        bp_en = 1'b0; run_sw = 1'b0;
        @(negedge Clk);
        check("t6_halt", state, HALT);
        check("t6_bp_hit", bp_hit, 0);
        run_sw = 1'b1; step_btn = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge Clk);
            if (i == 4) step_btn = 1'b0;
            check($sformatf("t6_adv_c%0d", i), advance, (i == 5 || i == 9) ? 1 : 0);
            check($sformatf("t6_state_c%0d", i), state, RUN);
        end
        run_sw = 1'b0;
        @(negedge Clk);
        check("t6_drop_adv", advance, 0);
        check("t6_drop_state", state, HALT);
        check("t6_drop_count", adv_count, 16);
        run_sw = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge Clk);
            check($sformatf("t6_rerun_adv_c%0d", i), advance, (i == 5) ? 1 : 0);
            check($sformatf("t6_rerun_state_c%0d", i), state, RUN);
        end
        check("t6_final_count", adv_count, 17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
